// File: rtl/bsg_gateway_bringup_pkg.sv
// Shared types and per-state helpers for the gateway-side ASIC link bring-up sequencer.
package bsg_gateway_bringup_pkg;

  typedef enum logic [3:0] {
    eAsicRst,
    eAsicWait,
    eRstHi,
    eRstLo,
    eLinkEn,
    eChipUnrst,
    eNodeEn,
    eCheck,
    eRun,
    eFail
  } bsg_bringup_state_e;

  typedef struct packed {
    logic asic_reset;
    logic reset;
    logic chip_reset;
    logic link_enable;
    logic node_en;
    logic done;
    logic error;
  } bsg_bringup_outs_s;

  // eRun and eFail are untimed; their dwell is never consulted.
  function automatic int unsigned bringup_dwell(input bsg_bringup_state_e state,
                                                input int unsigned asic_reset_cycles,
                                                input int unsigned asic_boot_cycles,
                                                input int unsigned step_cycles,
                                                input int unsigned timeout_cycles);
    case (state)
      eAsicRst:                                        return asic_reset_cycles;
      eAsicWait:                                       return asic_boot_cycles;
      eRstHi, eRstLo, eLinkEn, eChipUnrst, eNodeEn:    return step_cycles;
      eCheck:                                          return timeout_cycles;
      default:                                         return 1;
    endcase
  endfunction

  function automatic bsg_bringup_outs_s bringup_outs(input bsg_bringup_state_e state);
    bsg_bringup_outs_s outs;
    outs.asic_reset  = (state == eAsicRst);
    outs.reset       = (state == eRstHi);
    outs.link_enable = state inside {eLinkEn, eChipUnrst, eNodeEn, eCheck, eRun};
    outs.chip_reset  = !(state inside {eChipUnrst, eNodeEn, eCheck, eRun});
    outs.node_en     = state inside {eNodeEn, eCheck, eRun};
    outs.done        = (state == eRun);
    outs.error       = (state == eFail);
    return outs;
  endfunction

endpackage

// File: rtl/bsg_gateway_bringup_sequencer_counter.sv
// Dwell counter: synchronous clear, then optional increment, in the same cycle.
module bsg_counter_clear_up #(
  parameter int unsigned width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= (clear_i ? '0 : count_q) + width_p'(up_i);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_gateway_bringup_sequencer.sv
// Gateway-side bring-up FSM for one ASIC link: ASIC reset, local link/tunnel reset
// sequencing, liveness check with bounded retries, and sticky failure.
module bsg_gateway_bringup_sequencer
  import bsg_gateway_bringup_pkg::*;
#(
  parameter int unsigned asic_reset_cycles_p = 64,
  parameter int unsigned asic_boot_cycles_p  = 32768,
  parameter int unsigned step_cycles_p       = 5000,
  parameter int unsigned timeout_cycles_p    = 65535,
  parameter int unsigned max_retries_p       = 3,
  parameter int unsigned counter_width_p     = 16,
  localparam int unsigned retry_width_lp =
      (max_retries_p > 0) ? $clog2(max_retries_p + 1) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      restart_i,
  input  logic                      link_alive_i,
  input  logic                      test_error_i,
  output logic                      asic_reset_o,
  output logic                      reset_o,
  output logic                      chip_reset_o,
  output logic                      link_enable_o,
  output logic                      node_en_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [retry_width_lp-1:0] retry_count_o
);

  localparam longint unsigned max_a_lp = (asic_reset_cycles_p > asic_boot_cycles_p) ?
                                         asic_reset_cycles_p : asic_boot_cycles_p;
  localparam longint unsigned max_b_lp = (step_cycles_p > timeout_cycles_p) ?
                                         step_cycles_p : timeout_cycles_p;
  localparam longint unsigned max_dwell_lp = (max_a_lp > max_b_lp) ? max_a_lp : max_b_lp;

  if (asic_reset_cycles_p < 1 || asic_boot_cycles_p < 1 || step_cycles_p < 1 ||
      timeout_cycles_p < 1) begin : gen_bad_dwell
    $error("all dwell parameters must be at least 1");
  end
  if (counter_width_p < 1 || counter_width_p > 32 ||
      ((max_dwell_lp - 1) >> counter_width_p) != 0) begin : gen_bad_width
    $error("counter_width_p cannot hold the largest dwell");
  end

  bsg_bringup_state_e        state_q, state_d;
  logic [retry_width_lp-1:0] retry_q, retry_d;
  bsg_bringup_outs_s         outs_q;
  logic [counter_width_p-1:0] count;
  logic                      last_cycle;
  logic                      clear;

  assign last_cycle = (count == counter_width_p'(bringup_dwell(state_q, asic_reset_cycles_p,
                          asic_boot_cycles_p, step_cycles_p, timeout_cycles_p) - 1));

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      eAsicRst:   if (last_cycle) state_d = eAsicWait;
      eAsicWait:  if (last_cycle) state_d = eRstHi;
      eRstHi:     if (last_cycle) state_d = eRstLo;
      eRstLo:     if (last_cycle) state_d = eLinkEn;
      eLinkEn:    if (last_cycle) state_d = eChipUnrst;
      eChipUnrst: if (last_cycle) state_d = eNodeEn;
      eNodeEn:    if (last_cycle) state_d = eCheck;
      eCheck: begin
        if (link_alive_i) begin
          state_d = eRun;
        end else if (last_cycle) begin
          if (retry_q < retry_width_lp'(max_retries_p)) begin
            retry_d = retry_q + 1'b1;
            state_d = eAsicRst;
          end else begin
            state_d = eFail;
          end
        end
      end
      eRun:       if (test_error_i) state_d = eFail;
      eFail:      state_d = eFail;
      default:    state_d = eFail;
    endcase
    if (restart_i) begin
      state_d = eAsicRst;
      retry_d = '0;
    end
  end

  // Restart while already in eAsicRst must still rewind the dwell.
  assign clear = (state_d != state_q) || restart_i;

  bsg_counter_clear_up #(
    .width_p (counter_width_p)
  ) dwell_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear),
    .up_i    (!clear),
    .count_o (count)
  );

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eAsicRst;
      retry_q <= '0;
      outs_q  <= bringup_outs(eAsicRst);
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      outs_q  <= bringup_outs(state_d);
    end
  end

  assign asic_reset_o  = outs_q.asic_reset;
  assign reset_o       = outs_q.reset;
  assign chip_reset_o  = outs_q.chip_reset;
  assign link_enable_o = outs_q.link_enable;
  assign node_en_o     = outs_q.node_en;
  assign done_o        = outs_q.done;
  assign error_o       = outs_q.error;
  assign retry_count_o = retry_q;

endmodule

// File: tb/tb_bsg_gateway_bringup_sequencer.sv
// Self-checking bench: directed bring-up scenarios plus randomized traffic against
// a timeline model of the bring-up.
module tb_bsg_gateway_bringup_sequencer;

  localparam int A   = 3;
  localparam int B   = 5;
  localparam int S   = 4;
  localparam int T   = 6;
  localparam int R   = 1;
  localparam int RW  = $clog2(R + 1);
  localparam int OW  = 7 + RW;
  localparam int CHK = A + B + 5 * S;
  localparam logic [OW-1:0] RST_OUTS = {7'b1010000, {RW{1'b0}}};

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          restart_i = 1'b0;
  logic          link_alive_i = 1'b0;
  logic          test_error_i = 1'b0;
  logic          asic_reset_o, reset_o, chip_reset_o, link_enable_o, node_en_o;
  logic          done_o, error_o;
  logic [RW-1:0] retry_count_o;
  logic [OW-1:0] dut_outs;

  int vectors = 0;
  int miscompares = 0;

  // Model: 0 = bringing up (m_t cycles into the attempt), 1 = running, 2 = failed.
  int m_mode = 0;
  int m_t = 0;
  int m_retries = 0;

  always #5 clk = ~clk;

  bsg_gateway_bringup_sequencer #(
    .asic_reset_cycles_p (A),
    .asic_boot_cycles_p  (B),
    .step_cycles_p       (S),
    .timeout_cycles_p    (T),
    .max_retries_p       (R),
    .counter_width_p     (16)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .restart_i     (restart_i),
    .link_alive_i  (link_alive_i),
    .test_error_i  (test_error_i),
    .asic_reset_o  (asic_reset_o),
    .reset_o       (reset_o),
    .chip_reset_o  (chip_reset_o),
    .link_enable_o (link_enable_o),
    .node_en_o     (node_en_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .retry_count_o (retry_count_o)
  );

  assign dut_outs = {asic_reset_o, reset_o, chip_reset_o, link_enable_o, node_en_o,
                     done_o, error_o, retry_count_o};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] model_outs();
    logic a, r, c, l, n, d, e;
    a = 0; r = 0; c = 1; l = 0; n = 0; d = 0; e = 0;
    if (m_mode == 0) begin
      a = (m_t < A);
      r = (m_t >= A + B) && (m_t < A + B + S);
      l = (m_t >= A + B + 2 * S);
      c = (m_t < A + B + 3 * S);
      n = (m_t >= A + B + 4 * S);
    end else if (m_mode == 1) begin
      c = 0; l = 1; n = 1; d = 1;
    end else begin
      e = 1;
    end
    return {a, r, c, l, n, d, e, RW'(m_retries)};
  endfunction

  task automatic model_step();
    if (reset_i || restart_i) begin
      m_mode = 0; m_t = 0; m_retries = 0;
    end else if (m_mode == 0) begin
      if (m_t >= CHK && link_alive_i) begin
        m_mode = 1;
      end else if (m_t == CHK + T - 1) begin
        if (m_retries < R) begin
          m_retries++;
          m_t = 0;
        end else begin
          m_mode = 2;
        end
      end else begin
        m_t++;
      end
    end else if (m_mode == 1 && test_error_i) begin
      m_mode = 2;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("outs", 32'(dut_outs), 32'(model_outs()));
  endtask

  // Leaves the bench at cycle 0: reset just released, no edge since.
  task automatic reset_dut();
    reset_i = 1; restart_i = 0; link_alive_i = 0; test_error_i = 0;
    cycle();
    cycle();
    check_eq("reset_vals", 32'(dut_outs), 32'(RST_OUTS));
    reset_i = 0;
  endtask

  initial begin
    int first, rc, re_asic, re_retry, fail_at, alive_pct;
    #2;

    // Clean bring-up with the link immediately alive.
    reset_dut();
    link_alive_i = 1;
    first = -1;
    for (int c = 1; c <= 40; c++) begin
      cycle();
      if (done_o && first < 0) first = c;
    end
    check_eq("s1_done_cycle", 32'(first), 32'(CHK + 1));

    // Loopback error while running is sticky.
    test_error_i = 1;
    cycle();
    test_error_i = 0;
    check_eq("s4_fail_outs", 32'({done_o, error_o, link_enable_o}), 32'(3'b010));
    repeat (20) cycle();
    check_eq("s4_sticky", 32'({done_o, error_o}), 32'(2'b01));

    // Link never alive: one retry, then failure.
    reset_dut();
    re_asic = -1; re_retry = -1; fail_at = -1;
    for (int c = 1; c <= 80; c++) begin
      cycle();
      if (asic_reset_o && c >= A && re_asic < 0) begin
        re_asic = c;
        re_retry = int'(retry_count_o);
      end
      if (error_o && fail_at < 0) fail_at = c;
    end
    check_eq("s2_retry_cycle", 32'(re_asic), 32'(CHK + T));
    check_eq("s2_retry_count", 32'(re_retry), 32'(1));
    check_eq("s2_fail_cycle", 32'(fail_at), 32'(2 * (CHK + T)));
    check_eq("s2_enables", 32'({link_enable_o, node_en_o, done_o}), 32'(0));

    // Link comes alive in the second check window.
    reset_dut();
    first = -1; rc = -1;
    for (int c = 1; c <= 80; c++) begin
      cycle();
      if (c == 2 * CHK + T) link_alive_i = 1;
      if (done_o && first < 0) begin
        first = c;
        rc = int'(retry_count_o);
      end
    end
    check_eq("s3_done_cycle", 32'(first), 32'(2 * CHK + T + 1));
    check_eq("s3_retry_count", 32'(rc), 32'(1));

    // Restart wins over the eLinkEn dwell expiring on the same cycle.
    reset_dut();
    repeat (A + B + 3 * S - 1) cycle();
    restart_i = 1;
    cycle();
    restart_i = 0;
    check_eq("s5_restart", 32'({asic_reset_o, link_enable_o, error_o}), 32'(3'b100));
    repeat (A - 1) cycle();
    check_eq("s5_dwell_hold", 32'(asic_reset_o), 32'(1));
    cycle();
    check_eq("s5_dwell_clear", 32'(asic_reset_o), 32'(0));

    // Reset beats restart mid-check.
    reset_dut();
    repeat (CHK + 2) cycle();
    reset_i = 1;
    restart_i = 1;
    cycle();
    check_eq("s6_reset_prio", 32'(dut_outs), 32'(RST_OUTS));
    reset_i = 0;
    restart_i = 0;

    // Randomized traffic.
    alive_pct = 100;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       alive_pct = 0;
          1:       alive_pct = 3;
          default: alive_pct = 100;
        endcase
      end
      reset_i      = ($urandom_range(0, 399) == 0);
      restart_i    = ($urandom_range(0, 199) == 0);
      test_error_i = ($urandom_range(0, 49) == 0);
      link_alive_i = ($urandom_range(0, 99) < alive_pct);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
